// File: rtl/am_prod_accum.sv
// Streaming dot-product accumulator for 16-bit approximate-multiplier products.
// Define AM_ACC_SAT_EN to make the accumulator saturate; by default it wraps.
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no term taken yet, acc/cnt/ovf are zero
// ACCUM | at least one term taken, group still open
// HOLD  | completed group presented on out_*, input stalled
module am_prod_accum #(
    parameter int PW    = 16,
    parameter int ACC_W = 24,
    parameter int LEN   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             ovf;

    logic [ACC_W:0]   addExt;
    logic [ACC_W:0]   sumWide;
    logic [ACC_W-1:0] accNext;
    logic [7:0]       cntNext;
    logic             ovfNext;
    logic             carry;
    logic             accept;
    logic             closeGroup;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // One extra bit so the carry out of the accumulator is visible.
    assign addExt  = {{(ACC_W + 1 - PW){1'b0}}, in_prod};
    assign sumWide = {1'b0, acc} + addExt;
    assign carry   = sumWide[ACC_W];
    assign ovfNext = ovf | carry;
    assign cntNext = cnt + 8'd1;

`ifdef AM_ACC_SAT_EN
    // Once clamped, the group stays pinned at full scale.
    assign accNext = ovfNext ? {ACC_W{1'b1}} : sumWide[ACC_W-1:0];
`else
    assign accNext = sumWide[ACC_W-1:0];
`endif

    assign closeGroup = in_last || (({1'b0, cnt} + 9'd1) == 9'(LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (closeGroup) begin
                            out_sum   <= accNext;
                            out_count <= cntNext;
                            out_ovf   <= ovfNext;
                            acc       <= '0;
                            cnt       <= '0;
                            ovf       <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            acc   <= accNext;
                            cnt   <= cntNext;
                            ovf   <= ovfNext;
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_am_prod_accum.sv
// Scoreboard bench for am_prod_accum: directed scenarios plus random traffic,
// checked against a group-level arithmetic model (honours AM_ACC_SAT_EN).
module tb_am_prod_accum;

    localparam int PW    = 16;
    localparam int ACC_W = 16;
    localparam int LEN   = 4;
    localparam longint MAXV = (longint'(1) << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_ovf;

    am_prod_accum #(.PW(PW), .ACC_W(ACC_W), .LEN(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        int     count;
        bit     ovf;
    } res_t;

    res_t   expQ[$];
    longint terms[$];
    bit     expHold = 1'b0;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Group result straight from the list of accepted terms.
    task automatic closeGroupModel();
        res_t   r;
        longint total = 0;
        foreach (terms[i]) total += terms[i];
        r.count = terms.size();
        r.ovf   = (total > MAXV);
`ifdef AM_ACC_SAT_EN
        r.sum = (total > MAXV) ? MAXV : total;
`else
        r.sum = total % (MAXV + 1);
`endif
        expQ.push_back(r);
        terms.delete();
        expHold = 1'b1;
    endtask

    // Called at posedge+1; drives one cycle and advances the model.
    task automatic doCycle(input bit v, input int prod, input bit last, input bit ordy);
        in_valid  = v;
        in_prod   = prod[PW-1:0];
        in_last   = last;
        out_ready = ordy;
        chk("in_ready", longint'(in_ready), longint'(!expHold));
        chk("out_valid", longint'(out_valid), longint'(expHold));
        @(posedge clk);
        if (expHold) begin
            if (ordy) expHold = 1'b0;
        end else if (v) begin
            terms.push_back(longint'(prod & 32'hFFFF));
            if (last || terms.size() == LEN) closeGroupModel();
        end
        #1;
    endtask

    task automatic midReset();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst out_valid", longint'(out_valid), 0);
        chk("rst out_sum", longint'(out_sum), 0);
        chk("rst out_count", longint'(out_count), 0);
        chk("rst in_ready", longint'(in_ready), 1);
        #1 rst_n = 1'b1;
        expQ.delete();
        terms.delete();
        expHold = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares presented results; pops on the output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (expQ.size() == 0) begin
                    chk("unexpected result", longint'(out_sum), -1);
                end else begin
                    chk("out_sum", longint'(out_sum), expQ[0].sum);
                    chk("out_count", longint'(out_count), longint'(expQ[0].count));
                    chk("out_ovf", longint'(out_ovf), longint'(expQ[0].ovf));
                    if (out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset out_sum", longint'(out_sum), 0);
        chk("reset out_count", longint'(out_count), 0);
        chk("reset out_ovf", longint'(out_ovf), 0);
        chk("reset in_ready", longint'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full group back-to-back.
        doCycle(1, 100, 0, 1); doCycle(1, 200, 0, 1);
        doCycle(1, 300, 0, 1); doCycle(1, 400, 0, 1);
        doCycle(1, 7, 0, 1);
        doCycle(0, 0, 0, 1);  doCycle(0, 0, 0, 1);
        // Early last with overflow, then restart from zero.
        doCycle(1, 32'hFFFF, 0, 1); doCycle(1, 1, 1, 1);
        doCycle(0, 0, 0, 1);
        doCycle(1, 32'hFFFF, 0, 1); doCycle(1, 2, 1, 1);
        doCycle(0, 0, 0, 1);
        doCycle(1, 42, 1, 1); doCycle(0, 0, 0, 1);
        // Zero terms count but do not add.
        doCycle(1, 0, 0, 1); doCycle(1, 0, 1, 1); doCycle(0, 0, 0, 1);
        // Backpressure with in_valid held high.
        doCycle(1, 11, 1, 0);
        for (int i = 0; i < 5; i++) doCycle(1, 500 + i, 0, 0);
        doCycle(1, 999, 0, 1);
        doCycle(1, 13, 1, 1);
        doCycle(0, 0, 0, 1);
        // Reset mid-group, then a fresh full group.
        doCycle(1, 5, 0, 1); doCycle(1, 7, 0, 1);
        midReset();
        doCycle(1, 3, 0, 1); doCycle(1, 4, 0, 1);
        doCycle(1, 5, 0, 1); doCycle(1, 6, 0, 1);
        doCycle(0, 0, 0, 1);
        // Reset while a result is pending.
        doCycle(1, 77, 1, 0); doCycle(0, 0, 0, 0);
        midReset();
        // Single-term groups with continuous valid.
        doCycle(1, 9, 1, 1);  doCycle(1, 9, 1, 1);
        doCycle(1, 10, 1, 1); doCycle(1, 10, 1, 1);
        doCycle(1, 11, 1, 1); doCycle(1, 11, 1, 1);
        doCycle(0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            int p;
            case ($urandom_range(0, 3))
                0:       p = 0;
                1:       p = 32'hFFFF - int'($urandom_range(0, 15));
                default: p = int'($urandom_range(0, 32'hFFFF));
            endcase
            doCycle($urandom_range(0, 3) != 0, p, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 4; i++) doCycle(0, 0, 0, 1);
        chk("results drained", longint'(expQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
